// File: rtl/pad_scan_controller.sv
// Serial pad scanner: latches two pads, clocks BITS bits out of each, publishes
// the decoded (active-high) pad words, and serves them to a CPU read port.
module pad_scan_controller #(
    parameter int HALF_PERIOD = 150,
    parameter int BITS        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic [1:0]      pad_data,
    output logic            pad_latch,
    output logic            pad_clk,
    output logic            busy,
    output logic            state_valid,
    output logic [BITS-1:0] pad_state_0,
    output logic [BITS-1:0] pad_state_1,
    input  logic            read_en,
    input  logic            read_address,
    output logic [15:0]     read_data,
    output logic            read_ready,
    output logic [2:0]      dbg_state
);

    localparam int PW = $clog2(2 * HALF_PERIOD);
    localparam int CW = (BITS > 1) ? $clog2(BITS) : 1;
    localparam logic [PW-1:0] LATCH_LAST = PW'(2 * HALF_PERIOD - 1);
    localparam logic [PW-1:0] HALF_LAST  = PW'(HALF_PERIOD - 1);
    localparam logic [CW-1:0] BIT_LAST   = CW'(BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LATCH  = 3'd1,
        S_SAMPLE = 3'd2,
        S_CLK_LO = 3'd3,
        S_CLK_HI = 3'd4,
        S_DONE   = 3'd5
    } state_t;

    state_t          state_q;
    logic [PW-1:0]   phase_q;
    logic [CW-1:0]   bit_q;
    logic [BITS-1:0] shift0_q;
    logic [BITS-1:0] shift1_q;
    logic [1:0]      sync1_q;
    logic [1:0]      sync2_q;
    logic            pad_latch_q;
    logic            pad_clk_q;
    logic            busy_q;
    logic            state_valid_q;
    logic [BITS-1:0] pad_state_0_q;
    logic [BITS-1:0] pad_state_1_q;
    logic [15:0]     read_data_q;
    logic            read_ready_q;
    logic [15:0]     rd0_d;
    logic [15:0]     rd1_d;

    // Pads idle released (high), so the synchronizer resets to all ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q <= 2'b11;
            sync2_q <= 2'b11;
        end else begin
            sync1_q <= pad_data;
            sync2_q <= sync1_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            phase_q       <= '0;
            bit_q         <= '0;
            shift0_q      <= '0;
            shift1_q      <= '0;
            pad_latch_q   <= 1'b0;
            pad_clk_q     <= 1'b1;
            busy_q        <= 1'b0;
            state_valid_q <= 1'b0;
            pad_state_0_q <= '0;
            pad_state_1_q <= '0;
        end else begin
            state_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_LATCH;
                        phase_q     <= '0;
                        bit_q       <= '0;
                        pad_latch_q <= 1'b1;
                        busy_q      <= 1'b1;
                    end
                end
                S_LATCH: begin
                    if (phase_q == LATCH_LAST) begin
                        phase_q     <= '0;
                        state_q     <= S_SAMPLE;
                        pad_latch_q <= 1'b0;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_SAMPLE: begin
                    // Pad lines are active-low; store the pressed state as a 1.
                    shift0_q[bit_q] <= ~sync2_q[0];
                    shift1_q[bit_q] <= ~sync2_q[1];
                    if (bit_q == BIT_LAST) begin
                        state_q <= S_DONE;
                    end else begin
                        state_q   <= S_CLK_LO;
                        pad_clk_q <= 1'b0;
                    end
                end
                S_CLK_LO: begin
                    if (phase_q == HALF_LAST) begin
                        phase_q   <= '0;
                        state_q   <= S_CLK_HI;
                        pad_clk_q <= 1'b1;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_CLK_HI: begin
                    if (phase_q == HALF_LAST) begin
                        phase_q <= '0;
                        bit_q   <= bit_q + 1'b1;
                        state_q <= S_SAMPLE;
                    end else begin
                        phase_q <= phase_q + 1'b1;
                    end
                end
                S_DONE: begin
                    pad_state_0_q <= shift0_q;
                    pad_state_1_q <= shift1_q;
                    state_valid_q <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= S_IDLE;
                end
                default: begin
                    state_q     <= S_IDLE;
                    pad_latch_q <= 1'b0;
                    pad_clk_q   <= 1'b1;
                    busy_q      <= 1'b0;
                end
            endcase
        end
    end

    generate
        if (BITS >= 16) begin : g_rd_wide
            assign rd0_d = pad_state_0_q[15:0];
            assign rd1_d = pad_state_1_q[15:0];
        end else begin : g_rd_narrow
            assign rd0_d = {{(16 - BITS){1'b0}}, pad_state_0_q};
            assign rd1_d = {{(16 - BITS){1'b0}}, pad_state_1_q};
        end
    endgenerate

    // read_en is accepted every cycle (no backpressure); read_ready pulses for
    // exactly the cycle after the strobe and read_data holds until the next read.
    always_ff @(posedge clk) begin
        if (reset) begin
            read_data_q  <= '0;
            read_ready_q <= 1'b0;
        end else begin
            read_ready_q <= read_en;
            if (read_en) begin
                read_data_q <= read_address ? rd1_d : rd0_d;
            end
        end
    end

    assign pad_latch   = pad_latch_q;
    assign pad_clk     = pad_clk_q;
    assign busy        = busy_q;
    assign state_valid = state_valid_q;
    assign pad_state_0 = pad_state_0_q;
    assign pad_state_1 = pad_state_1_q;
    assign read_data   = read_data_q;
    assign read_ready  = read_ready_q;
    assign dbg_state   = state_q;

endmodule

// File: tb/tb_pad_scan_controller.sv
// Randomized bench for pad_scan_controller: a scan-level timing model predicts
// waveforms, published words and read results; monitors pop expected queues.
module tb_pad_scan_controller;

    localparam int HP   = 4;
    localparam int NB   = 16;
    localparam int PER  = 2 * HP + 1;
    localparam int LAST = NB * PER + 1;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    pad_data;
    logic          pad_latch;
    logic          pad_clk;
    logic          busy;
    logic          state_valid;
    logic [NB-1:0] pad_state_0;
    logic [NB-1:0] pad_state_1;
    logic          read_en = 1'b0;
    logic          read_address = 1'b0;
    logic [15:0]   read_data;
    logic          read_ready;
    logic [2:0]    dbg_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    pad_scan_controller #(.HALF_PERIOD(HP), .BITS(NB)) dut (
        .clk(clk), .reset(reset), .start(start), .pad_data(pad_data),
        .pad_latch(pad_latch), .pad_clk(pad_clk), .busy(busy),
        .state_valid(state_valid), .pad_state_0(pad_state_0),
        .pad_state_1(pad_state_1), .read_en(read_en),
        .read_address(read_address), .read_data(read_data),
        .read_ready(read_ready), .dbg_state(dbg_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Pad model: latch reloads bit 0, each pad_clk rise advances one bit.
    logic [15:0] raw0 = 16'hFFFF;
    logic [15:0] raw1 = 16'hFFFF;
    int          pidx = NB;
    logic        prev_clk = 1'b1;
    always @(negedge clk) begin
        if (pad_latch === 1'b1) pidx = 0;
        else if (pad_clk === 1'b1 && prev_clk === 1'b0) pidx = pidx + 1;
        prev_clk = pad_clk;
    end
    assign pad_data = (pidx < NB) ? {raw1[pidx[3:0]], raw0[pidx[3:0]]} : 2'b11;

    logic [63:0] exp_sv_q[$];
    logic [47:0] exp_rd_q[$];

    bit          scan_act = 1'b0;
    int          scan_s = 0;
    logic [15:0] pub0 = '0, pub1 = '0, pend0 = '0, pend1 = '0, rd_hold = '0;
    logic [15:0] nw0 = '0, nw1 = '0;
    int          accepted = 0;

    bit          nxt_valid = 1'b0, cur_valid = 1'b0;
    logic        nxt_latch, nxt_clk, nxt_busy, cur_latch, cur_clk, cur_busy;
    logic [15:0] nxt_pub0, nxt_pub1, nxt_rd, cur_pub0, cur_pub1, cur_rd;

    always @(posedge clk) begin
        cur_valid <= nxt_valid;
        cur_latch <= nxt_latch;
        cur_clk   <= nxt_clk;
        cur_busy  <= nxt_busy;
        cur_pub0  <= nxt_pub0;
        cur_pub1  <= nxt_pub1;
        cur_rd    <= nxt_rd;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s edge %0d actual %h required %h", name, cyc, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (cur_valid) begin
            chk("pad_latch", 32'(pad_latch), 32'(cur_latch));
            chk("pad_clk", 32'(pad_clk), 32'(cur_clk));
            chk("busy", 32'(busy), 32'(cur_busy));
            chk("pad_state_0", 32'(pad_state_0), 32'(cur_pub0));
            chk("pad_state_1", 32'(pad_state_1), 32'(cur_pub1));
            chk("read_data_hold", 32'(read_data), 32'(cur_rd));
        end
    end

    logic [63:0] sv_it;
    logic [47:0] rd_it;
    always @(negedge clk) begin
        if (state_valid === 1'b1) begin
            if (exp_sv_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_state_valid edge %0d actual 1 required 0", cyc);
            end else begin
                sv_it = exp_sv_q.pop_front();
                chk("sv_edge", cyc, sv_it[63:32]);
                chk("sv_pad0", 32'(pad_state_0), 32'(sv_it[15:0]));
                chk("sv_pad1", 32'(pad_state_1), 32'(sv_it[31:16]));
            end
        end
        if (read_ready === 1'b1) begin
            if (exp_rd_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_read_ready edge %0d actual 1 required 0", cyc);
            end else begin
                rd_it = exp_rd_q.pop_front();
                chk("rd_edge", cyc, rd_it[47:16]);
                chk("rd_data", 32'(read_data), 32'(rd_it[15:0]));
            end
        end
    end

    // Drive one cycle of inputs and predict the outputs after the next edge.
    task automatic step(input bit rst, input bit st, input bit rden, input bit rda);
        int e;
        int o;
        logic [15:0] rv;
        e = cyc + 1;
        reset = rst;
        start = st;
        read_en = rden;
        read_address = rda;
        if (rst) begin
            scan_act = 1'b0;
            pub0 = '0;
            pub1 = '0;
            rd_hold = '0;
            exp_sv_q.delete();
        end else begin
            if (rden) begin
                rv = rda ? pub1 : pub0;
                rd_hold = rv;
                exp_rd_q.push_back({e, rv});
            end
            if (scan_act && (e - scan_s == LAST)) begin
                pub0 = pend0;
                pub1 = pend1;
                scan_act = 1'b0;
            end else if (!scan_act && st) begin
                scan_act = 1'b1;
                scan_s = e;
                pend0 = nw0;
                pend1 = nw1;
                raw0 = ~nw0;
                raw1 = ~nw1;
                exp_sv_q.push_back({32'(e + LAST), nw1, nw0});
                accepted++;
            end
        end
        nxt_valid = 1'b1;
        if (scan_act) begin
            o = e - scan_s;
            nxt_latch = (o < 2 * HP);
            nxt_clk = !((o >= PER) && (((o - PER) % PER) < HP) && (o < NB * PER));
            nxt_busy = 1'b1;
        end else begin
            nxt_latch = 1'b0;
            nxt_clk = 1'b1;
            nxt_busy = 1'b0;
        end
        nxt_pub0 = pub0;
        nxt_pub1 = pub1;
        nxt_rd = rd_hold;
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step(1'b0, 1'b0, 1'b0, 1'b0);

        // Known words, extra starts mid-scan, reads around the publish edge.
        nw0 = 16'hA55A;
        nw1 = 16'h0F0F;
        for (int o = 0; o < 150; o++) begin
            step(1'b0, (o == 0) || (o == 20) || (o == 100),
                 (o >= 145) && (o <= 147), (o != 147));
        end

        // Reset 50 edges into a scan; nothing may be published afterwards.
        nw0 = 16'($urandom());
        nw1 = 16'($urandom());
        for (int o = 0; o <= 50; o++) step(o == 50, o == 0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, (i % 37) == 5, i[0]);

        // start held high: back-to-back scans.
        for (int i = 0; i < 460; i++) begin
            if (scan_act == 1'b0) begin
                nw0 = 16'($urandom());
                nw1 = 16'($urandom());
            end
            step(1'b0, 1'b1, 1'b0, 1'b0);
        end

        for (int i = 0; i < 3000; i++) begin
            if (scan_act == 1'b0) begin
                nw0 = 16'($urandom());
                nw1 = 16'($urandom());
            end
            step($urandom_range(0, 1499) == 0, $urandom_range(0, 49) == 0,
                 $urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)));
        end

        for (int i = 0; i < 200; i++) step(1'b0, 1'b0, 1'b0, 1'b0);
        chk("sv_queue_left", exp_sv_q.size(), 0);
        chk("rd_queue_left", exp_rd_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pad_scan_controller.md
PAD_SCAN_CONTROLLER -- requirements
Module: pad_scan_controller

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 150: cycles per pad_clk half-period; latch pulse is 2*HALF_PERIOD; legal range 4..4095.
REQ-002 SHALL have parameter BITS, default 16: bits shifted per pad per scan.
REQ-003 SHALL have port clk, input, 1: single clock, all logic on rising edge.
REQ-004 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port start, input, 1: scan request (frame-end pulse); level-sampled each cycle.
REQ-006 SHALL have port pad_data, input, 2: serial data from pad 0 / pad 1; active-low.
REQ-007 SHALL have port pad_latch, output, 1: latch strobe to pads.
REQ-008 SHALL have port pad_clk, output, 1: shift clock to pads; idles high.
REQ-009 SHALL have port busy, output, 1: high while a scan is in progress.
REQ-010 SHALL have port state_valid, output, 1: one-cycle pulse when new pad state is published.
REQ-011 SHALL have port pad_state_0, output, BITS: last published pad 0 state; active-high, bit k = k-th shifted bit.
REQ-012 SHALL have port pad_state_1, output, BITS: last published pad 1 state.
REQ-013 SHALL have port read_en, input, 1: CPU read strobe.
REQ-014 SHALL have port read_address, input, 1: 0 selects pad 0, 1 selects pad 1.
REQ-015 SHALL have port read_data, output, 16: registered read result, zero-extended if BITS < 16.
REQ-016 SHALL have port read_ready, output, 1: one-cycle pulse, read_data valid.

Function
REQ-017 SHALL pass pad_data through a 2-FF synchronizer; all sampling uses the synchronized value.
REQ-018 SHALL implement FSM states IDLE, LATCH, SAMPLE, CLK_LO, CLK_HI, DONE.
REQ-019 IDLE: pad_latch=0, pad_clk=1, busy=0; start=1 -> LATCH on next edge, bit counter cleared.
REQ-020 LATCH: pad_latch=1, pad_clk=1 for exactly 2*HALF_PERIOD cycles, then -> SAMPLE.
REQ-021 SAMPLE (one cycle): shift reg bit[count] <= ~sync_pad_data per pad; if count==BITS-1 -> DONE, else -> CLK_LO.
REQ-022 CLK_LO: pad_clk=0 for HALF_PERIOD cycles -> CLK_HI; CLK_HI: pad_clk=1 for HALF_PERIOD cycles, count+1 -> SAMPLE.
REQ-023 DONE (one cycle): pad_state_0/1 <= shift regs and state_valid=1 on the same edge; then -> IDLE.
REQ-024 busy SHALL be high in every state except IDLE.
REQ-025 With start sampled at edge 0, sample k SHALL occur at edge (k+1)*(2*HALF_PERIOD+1); state_valid SHALL be high for the cycle following edge BITS*(2*HALF_PERIOD+1)+1.
REQ-026 start asserted while busy=1 SHALL be ignored (not queued); start held high SHALL restart a scan on the first IDLE cycle.
REQ-027 pad_latch and pad_clk SHALL be registered outputs, glitch-free; pad_clk never low while pad_latch high.
REQ-028 Read: read_en=1 at edge N -> read_data = selected pad_state, read_ready=1, for the cycle after edge N; read_ready=0 otherwise; read_data holds its value between reads.
REQ-029 Read coincident with DONE update SHALL return the pre-update value.
REQ-030 Reads SHALL be accepted in every FSM state and never stall.
REQ-031 Counters SHALL not wrap: bit counter sized for BITS-1, phase counter for 2*HALF_PERIOD-1.

Reset
REQ-032 On reset=1 (including mid-scan): FSM -> IDLE, pad_latch=0, pad_clk=1, busy=0, state_valid=0, read_ready=0, read_data=0, pad_state_0/1=0, shift regs and counters=0, synchronizer=2'b11.
REQ-033 First scan after reset SHALL start only on a start sampled after reset deasserts.

Verification (HALF_PERIOD=4, BITS=16)
REQ-034 Pad model drives pad 0 = ~16'hA55A, pad 1 = ~16'h0F0F LSB-first; single start pulse -> state_valid pulse after edge 145; pad_state_0=16'hA55A, pad_state_1=16'h0F0F.
REQ-035 Waveform check: pad_latch high exactly 8 cycles; 15 pad_clk low pulses each 4 cycles; pad_clk high while latch high; busy high from edge 1 through DONE.
REQ-036 start pulsed again at edges 20 and 100 during scan -> ignored; exactly one state_valid; start held high -> back-to-back scans, one IDLE cycle between.
REQ-037 reset asserted at edge 50 mid-scan -> next cycle pad_latch=0, pad_clk=1, busy=0, pad_state_0/1=0; no state_valid until a new start.
REQ-038 read_en with read_address=1 on the DONE cycle -> read_ready pulse, read_data = old value (0 on first scan); repeat next cycle -> 16'h0F0F.
